control_sequencer: RTL

Microcode-free, state-machine sequencer for the relay computer. It fetches each instruction through the program-control unit and decodes the instruction register. It then drives, one state per clock, the load/select strobes, ALU function code, memory read/write and halt lines of the control-signal bundle. Outputs feed the register unit, program-control unit, ALU and memory. Condition flags come back from the flag register.

---
 rtl/relay_pkg.sv | 88 ++++++++
 rtl/instruction_decoder.sv | 49 ++++
 rtl/control_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/relay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : relay_pkg                                                     |
// | Description: Shared types for the relay-computer control sequencer:       |
// |              sequencer state enum, register-index enum, opcode classes,   |
// |              opcode field masks/patterns and small decode helpers.        |
// | Revision   : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package relay_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'd0,
    ST_F1   = 5'd1,
    ST_F2   = 5'd2,
    ST_DEC  = 5'd3,
    ST_MOV  = 5'd4,
    ST_SET  = 5'd5,
    ST_ALU  = 5'd6,
    ST_LD   = 5'd7,
    ST_ST   = 5'd8,
    ST_NOP  = 5'd9,
    ST_IX1  = 5'd10,
    ST_IX2  = 5'd11,
    ST_G1   = 5'd12,
    ST_G2   = 5'd13,
    ST_G3   = 5'd14,
    ST_G4   = 5'd15,
    ST_G5   = 5'd16,
    ST_HLT  = 5'd17
  } seqState_t;

  typedef enum logic [2:0] {
    REG_A  = 3'd0,
    REG_B  = 3'd1,
    REG_C  = 3'd2,
    REG_D  = 3'd3,
    REG_M1 = 3'd4,
    REG_M2 = 3'd5,
    REG_X  = 3'd6,
    REG_Y  = 3'd7
  } regIdx_t;

  typedef enum logic [3:0] {
    OP_MOV   = 4'd0,
    OP_SET   = 4'd1,
    OP_ALU   = 4'd2,
    OP_LD    = 4'd3,
    OP_ST    = 4'd4,
    OP_INCXY = 4'd5,
    OP_HALT  = 4'd6,
    OP_GOTO  = 4'd7,
    OP_NOP   = 4'd8
  } opClass_t;

  // Opcode field masks and the pattern each class must match under its mask.
  localparam logic [7:0] c_MASK_TOP2  = 8'hC0;
  localparam logic [7:0] c_MASK_TOP4  = 8'hF0;
  localparam logic [7:0] c_MASK_TOP6  = 8'hFC;
  localparam logic [7:0] c_MASK_FULL  = 8'hFF;
  localparam logic [7:0] c_PAT_MOV    = 8'h00;
  localparam logic [7:0] c_PAT_SET    = 8'h40;
  localparam logic [7:0] c_PAT_ALU    = 8'h80;
  localparam logic [7:0] c_PAT_LD     = 8'h90;
  localparam logic [7:0] c_PAT_ST     = 8'h98;
  localparam logic [7:0] c_PAT_INCXY  = 8'hB0;
  localparam logic [7:0] c_PAT_HALT   = 8'hAE;
  localparam logic [7:0] c_PAT_GOTO   = 8'hC0;

  function automatic opClass_t classify(input logic [7:0] inst);
    opClass_t cls;
    if ((inst & c_MASK_TOP2) == c_PAT_MOV)        cls = OP_MOV;
    else if ((inst & c_MASK_TOP2) == c_PAT_SET)   cls = OP_SET;
    else if ((inst & c_MASK_TOP2) == c_PAT_GOTO)  cls = OP_GOTO;
    else if ((inst & c_MASK_TOP4) == c_PAT_ALU)   cls = OP_ALU;
    else if ((inst & c_MASK_TOP6) == c_PAT_LD)    cls = OP_LD;
    else if ((inst & c_MASK_TOP6) == c_PAT_ST)    cls = OP_ST;
    else if ((inst & c_MASK_FULL) == c_PAT_INCXY) cls = OP_INCXY;
    else if ((inst & c_MASK_FULL) == c_PAT_HALT)  cls = OP_HALT;
    else                                          cls = OP_NOP;
    return cls;
  endfunction

  function automatic logic [7:0] signExt5(input logic [4:0] v);
    return {{3{v[4]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : instruction_decoder                                           |
// | Description: Combinational split of the instruction register into an     |
// |              opcode class and its operand fields.                          |
// |   inst     in  8  instruction register contents                          |
// |   opClass  out    opcode class                                           |
// |   dstReg   out    destination register (MOV/SET/ALU/LD) or source (ST)   |
// |   srcReg   out    MOV source register                                    |
// |   aluFn    out 3  ALU function code                                      |
// |   cond     out 3  GOTO condition bits {s,c,z}                            |
// |   immValue out 8  sign-extended SET immediate                            |
// | Revision   : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instruction_decoder
  import relay_pkg::*;
(
  input  logic [7:0] inst,
  output opClass_t   opClass,
  output regIdx_t    dstReg,
  output regIdx_t    srcReg,
  output logic [2:0] aluFn,
  output logic [2:0] cond,
  output logic [7:0] immValue
);

  always_comb begin
    opClass  = classify(inst);
    dstReg   = REG_A;
    srcReg   = REG_A;
    aluFn    = inst[2:0];
    cond     = inst[5:3];
    immValue = signExt5(inst[4:0]);
    case (opClass)
      OP_MOV: begin
        dstReg = regIdx_t'(inst[5:3]);
        srcReg = regIdx_t'(inst[2:0]);
      end
      OP_SET:  dstReg = inst[5] ? REG_B : REG_A;
      OP_ALU:  dstReg = inst[3] ? REG_D : REG_A;
      // LD/ST only reach A..D, so the top index bit is always zero.
      OP_LD,
      OP_ST:   dstReg = regIdx_t'({1'b0, inst[1:0]});
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : control_sequencer                                             |
// | Description: Hard-wired state-machine sequencer for the relay computer.   |
// |              Fetches through the program-control unit, decodes the held   |
// |              instruction register and drives one control state per clock.|
// |   clk, rst_n          clock, async active-low reset                      |
// |   run                 start a new instruction at each boundary           |
// |   inst                held instruction register                          |
// |   zero/carry/sign     latched ALU flags (used in G5 only)                |
// |   Ld*                 single-cycle load strobes                          |
// |   Sel*                bus-drive selects                                   |
// |   imm_en/imm_value    SET immediate onto the data bus                    |
// |   alu_en/AluFunctionCode  ALU result onto the data bus                   |
// |   MemRead/MemWrite/Halt   memory and halt lines                          |
// | Revision   : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module control_sequencer
  import relay_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [7:0] inst,
  input  logic       zero,
  input  logic       carry,
  input  logic       sign,
  output logic       LdA,
  output logic       LdB,
  output logic       LdC,
  output logic       LdD,
  output logic       LdM1,
  output logic       LdM2,
  output logic       LdX,
  output logic       LdY,
  output logic       LdXY,
  output logic       LdJ1,
  output logic       LdJ2,
  output logic       LdInst,
  output logic       LdPC,
  output logic       LdINC,
  output logic       LdCC,
  output logic       SelA,
  output logic       SelB,
  output logic       SelC,
  output logic       SelD,
  output logic       SelM1,
  output logic       SelM2,
  output logic       SelX,
  output logic       SelY,
  output logic       SelM,
  output logic       SelXY,
  output logic       SelJ,
  output logic       SelPC,
  output logic       SelINC,
  output logic       imm_en,
  output logic [7:0] imm_value,
  output logic       alu_en,
  output logic [2:0] AluFunctionCode,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Halt
);

  seqState_t  r_state;
  seqState_t  w_nextState;
  seqState_t  w_boundary;
  opClass_t   w_opClass;
  regIdx_t    w_dstReg;
  regIdx_t    w_srcReg;
  logic [2:0] w_aluFn;
  logic [2:0] w_cond;
  logic [7:0] w_immValue;
  logic       w_taken;
  logic [7:0] w_ldReg;
  logic [7:0] w_selReg;

  instruction_decoder u_decoder (
    .inst     (inst),
    .opClass  (w_opClass),
    .dstReg   (w_dstReg),
    .srcReg   (w_srcReg),
    .aluFn    (w_aluFn),
    .cond     (w_cond),
    .immValue (w_immValue)
  );

  // cond = {s, c, z}; an all-zero condition field is an unconditional jump.
  assign w_taken = (w_cond == 3'b000) | (w_cond[2] & sign) |
                   (w_cond[1] & carry) | (w_cond[0] & zero);

  // Where every instruction goes after its last execute state.
  assign w_boundary = run ? ST_F1 : ST_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: w_nextState = run ? ST_F1 : ST_IDLE;
      ST_F1:   w_nextState = ST_F2;
      ST_F2:   w_nextState = ST_DEC;
      ST_DEC: begin
        case (w_opClass)
          OP_MOV:   w_nextState = ST_MOV;
          OP_SET:   w_nextState = ST_SET;
          OP_ALU:   w_nextState = ST_ALU;
          OP_LD:    w_nextState = ST_LD;
          OP_ST:    w_nextState = ST_ST;
          OP_INCXY: w_nextState = ST_IX1;
          OP_HALT:  w_nextState = ST_HLT;
          OP_GOTO:  w_nextState = ST_G1;
          default:  w_nextState = ST_NOP;
        endcase
      end
      ST_IX1:  w_nextState = ST_IX2;
      ST_G1:   w_nextState = ST_G2;
      ST_G2:   w_nextState = ST_G3;
      ST_G3:   w_nextState = ST_G4;
      ST_G4:   w_nextState = ST_G5;
      ST_MOV, ST_SET, ST_ALU, ST_LD, ST_ST, ST_NOP, ST_IX2, ST_G5:
               w_nextState = w_boundary;
      ST_HLT:  w_nextState = ST_HLT;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Moore output decode: state plus the held instruction register.
  always_comb begin
    w_ldReg         = '0;
    w_selReg        = '0;
    LdXY            = 1'b0;
    LdJ1            = 1'b0;
    LdJ2            = 1'b0;
    LdInst          = 1'b0;
    LdPC            = 1'b0;
    LdINC           = 1'b0;
    LdCC            = 1'b0;
    SelM            = 1'b0;
    SelXY           = 1'b0;
    SelJ            = 1'b0;
    SelPC           = 1'b0;
    SelINC          = 1'b0;
    imm_en          = 1'b0;
    imm_value       = '0;
    alu_en          = 1'b0;
    AluFunctionCode = '0;
    MemRead         = 1'b0;
    MemWrite        = 1'b0;
    Halt            = 1'b0;
    case (r_state)
      ST_F1, ST_G1: begin
        SelPC   = 1'b1;
        MemRead = 1'b1;
        LdINC   = 1'b1;
        if (r_state == ST_F1) LdInst = 1'b1;
        else                  LdJ1   = 1'b1;
      end
      ST_G3: begin
        SelPC   = 1'b1;
        MemRead = 1'b1;
        LdJ2    = 1'b1;
        LdINC   = 1'b1;
      end
      ST_F2, ST_G2, ST_G4: begin
        SelINC = 1'b1;
        LdPC   = 1'b1;
      end
      ST_MOV: begin
        // A self-move leaves the bus undriven, so the register loads zero.
        w_ldReg[w_dstReg] = 1'b1;
        if (w_srcReg != w_dstReg) w_selReg[w_srcReg] = 1'b1;
      end
      ST_SET: begin
        imm_en            = 1'b1;
        imm_value         = w_immValue;
        w_ldReg[w_dstReg] = 1'b1;
      end
      ST_ALU: begin
        alu_en            = 1'b1;
        AluFunctionCode   = w_aluFn;
        LdCC              = 1'b1;
        w_ldReg[w_dstReg] = 1'b1;
      end
      ST_LD: begin
        SelM              = 1'b1;
        MemRead           = 1'b1;
        w_ldReg[w_dstReg] = 1'b1;
      end
      ST_ST: begin
        SelM               = 1'b1;
        w_selReg[w_dstReg] = 1'b1;
        MemWrite           = 1'b1;
      end
      ST_IX1: begin
        SelXY = 1'b1;
        LdINC = 1'b1;
      end
      ST_IX2: begin
        SelINC = 1'b1;
        LdXY   = 1'b1;
      end
      ST_G5: begin
        if (w_taken) begin
          SelJ = 1'b1;
          LdPC = 1'b1;
        end
      end
      ST_HLT:  Halt = 1'b1;
      default: ;
    endcase
  end

  assign LdA   = w_ldReg[REG_A];
  assign LdB   = w_ldReg[REG_B];
  assign LdC   = w_ldReg[REG_C];
  assign LdD   = w_ldReg[REG_D];
  assign LdM1  = w_ldReg[REG_M1];
  assign LdM2  = w_ldReg[REG_M2];
  assign LdX   = w_ldReg[REG_X];
  assign LdY   = w_ldReg[REG_Y];
  assign SelA  = w_selReg[REG_A];
  assign SelB  = w_selReg[REG_B];
  assign SelC  = w_selReg[REG_C];
  assign SelD  = w_selReg[REG_D];
  assign SelM1 = w_selReg[REG_M1];
  assign SelM2 = w_selReg[REG_M2];
  assign SelX  = w_selReg[REG_X];
  assign SelY  = w_selReg[REG_Y];

endmodule
`default_nettype wire
